// File: rtl/cache_line_server_broadcast_pkg.sv
// rtl/cache_line_server_broadcast_pkg.sv - shared types and constants for the cache line server
package cache_line_server_broadcast_pkg;

    // Server sequencing: pick a requester, wait out the RAM latency, strobe the line out.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEFAULT_LINE_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH      = 64;

    // Width needed to hold an index in [0, n-1]; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_line_server_broadcast_rr_arbiter.sv
// rtl/cache_line_server_broadcast_rr_arbiter.sv - combinational round-robin request picker
module rr_arbiter
    import cache_line_server_broadcast_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [N_PORTS-1:0] o_grant_oh,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [PTR_W-1:0] w_idx;
    int               w_sum;

    // Walk the ports starting at the pointer, wrapping past the top; the first requester wins.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = '0;
        w_sum       = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_sum = int'(i_rr_ptr) + k;
            if (w_sum >= N_PORTS) begin
                w_sum = w_sum - N_PORTS;
            end
            w_idx = PTR_W'(w_sum);
            if (!o_any && i_req[w_idx]) begin
                o_any             = 1'b1;
                o_grant_oh[w_idx] = 1'b1;
                o_grant_idx       = w_idx;
            end
        end
    end

endmodule

// File: rtl/cache_line_server_broadcast.sv
// rtl/cache_line_server_broadcast.sv - round-robin line-miss server with broadcast fill
module cache_line_server_broadcast
    import cache_line_server_broadcast_pkg::*;
#(
    parameter int N_PORTS         = 4,
    parameter int LINE_ADDR_WIDTH = DEFAULT_LINE_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [N_PORTS-1:0]                 i_req_valid,
    input  logic [N_PORTS*LINE_ADDR_WIDTH-1:0] i_req_addr,
    output logic [N_PORTS-1:0]                 o_req_ready,
    output logic [DATA_WIDTH-1:0]              o_line_data,
    output logic                               o_bcast_valid,
    output logic [LINE_ADDR_WIDTH-1:0]         o_bcast_addr,
    output logic                               o_mem_rd_en,
    output logic [LINE_ADDR_WIDTH-1:0]         o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]              i_mem_rd_data
);

    localparam int PTR_W = idx_width(N_PORTS);
    // The counter only ever holds MEM_LATENCY-1 down to 0.
    localparam int CNT_W = idx_width(MEM_LATENCY);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_issue;

    logic [PTR_W-1:0]           r_rr_ptr;
    logic [N_PORTS-1:0]         r_grant_oh;
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]      r_line_data;
    logic [LINE_ADDR_WIDTH-1:0] r_bcast_addr;
    logic [LINE_ADDR_WIDTH-1:0] r_mem_rd_addr;

    logic [N_PORTS-1:0]         w_grant_oh;
    logic [PTR_W-1:0]           w_grant_idx;
    logic                       w_any;
    logic [LINE_ADDR_WIDTH-1:0] w_grant_addr;
    logic [PTR_W-1:0]           w_ptr_next;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_grant_addr = i_req_addr[w_grant_idx*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
    assign w_ptr_next   = (w_grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; a read is issued in the same IDLE cycle the grant is made.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_issue      = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, latency countdown and line capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr      <= '0;
            r_grant_oh    <= '0;
            r_cnt         <= '0;
            r_line_data   <= '0;
            r_bcast_addr  <= '0;
            r_mem_rd_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_grant_oh    <= w_grant_oh;
                        r_bcast_addr  <= w_grant_addr;
                        r_mem_rd_addr <= w_grant_addr;
                        r_cnt         <= CNT_W'(MEM_LATENCY - 1);
                        r_rr_ptr      <= w_ptr_next;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_line_data <= i_mem_rd_data;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The RAM sees the read in the grant cycle itself; reset masks it so an aborted cycle issues nothing.
    assign o_mem_rd_en   = w_issue & ~i_rst;
    assign o_mem_rd_addr = (w_issue & ~i_rst) ? w_grant_addr : r_mem_rd_addr;

    assign o_req_ready   = (r_state == S_RESP) ? r_grant_oh : '0;
    assign o_bcast_valid = (r_state == S_RESP);
    assign o_bcast_addr  = r_bcast_addr;
    assign o_line_data   = r_line_data;

endmodule

// File: tb/tb_cache_line_server_broadcast.sv
// tb/tb_cache_line_server_broadcast.sv - scoreboard bench for the cache line server
module tb_cache_line_server_broadcast;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam logic [DW-1:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct packed {
        logic [NP-1:0] mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [NP-1:0]    req_valid = '0;
    logic [NP*AW-1:0] req_addr  = '0;

    logic [NP-1:0] m_req_ready, l1_req_ready, l4_req_ready;
    logic [DW-1:0] m_line_data, l1_line_data, l4_line_data;
    logic          m_bcast_valid, l1_bcast_valid, l4_bcast_valid;
    logic [AW-1:0] m_bcast_addr, l1_bcast_addr, l4_bcast_addr;
    logic          m_rd_en, l1_rd_en, l4_rd_en;
    logic [AW-1:0] m_rd_addr, l1_rd_addr, l4_rd_addr;
    logic [DW-1:0] m_rd_data, l1_rd_data, l4_rd_data;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
        if (a == 12'h0A3) return 64'hDEADBEEF_00C0FFEE;
        return {20'hC0DE0, a, 20'h5EED0, ~a};
    endfunction

    cache_line_server_broadcast #(.N_PORTS(NP), .LINE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .o_req_ready(m_req_ready), .o_line_data(m_line_data), .o_bcast_valid(m_bcast_valid),
        .o_bcast_addr(m_bcast_addr), .o_mem_rd_en(m_rd_en), .o_mem_rd_addr(m_rd_addr), .i_mem_rd_data(m_rd_data)
    );

    cache_line_server_broadcast #(.N_PORTS(NP), .LINE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .o_req_ready(l1_req_ready), .o_line_data(l1_line_data), .o_bcast_valid(l1_bcast_valid),
        .o_bcast_addr(l1_bcast_addr), .o_mem_rd_en(l1_rd_en), .o_mem_rd_addr(l1_rd_addr), .i_mem_rd_data(l1_rd_data)
    );

    cache_line_server_broadcast #(.N_PORTS(NP), .LINE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(4)) dut_l4 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .o_req_ready(l4_req_ready), .o_line_data(l4_line_data), .o_bcast_valid(l4_bcast_valid),
        .o_bcast_addr(l4_bcast_addr), .o_mem_rd_en(l4_rd_en), .o_mem_rd_addr(l4_rd_addr), .i_mem_rd_data(l4_rd_data)
    );

    // RAM models: data is valid exactly MEM_LATENCY cycles after the read enable, poison otherwise.
    logic [1:0]    m_pv = '0;
    logic [DW-1:0] m_pd0, m_pd1;
    always @(posedge clk) begin
        m_pv  <= {m_pv[0], m_rd_en};
        m_pd0 <= ram_fn(m_rd_addr);
        m_pd1 <= m_pd0;
    end
    assign m_rd_data = m_pv[1] ? m_pd1 : POISON;

    logic          l1_pv = 1'b0;
    logic [DW-1:0] l1_pd;
    always @(posedge clk) begin
        l1_pv <= l1_rd_en;
        l1_pd <= ram_fn(l1_rd_addr);
    end
    assign l1_rd_data = l1_pv ? l1_pd : POISON;

    logic [3:0]    l4_pv = '0;
    logic [DW-1:0] l4_pd [4];
    always @(posedge clk) begin
        l4_pv    <= {l4_pv[2:0], l4_rd_en};
        l4_pd[0] <= ram_fn(l4_rd_addr);
        for (int i = 1; i < 4; i++) l4_pd[i] <= l4_pd[i-1];
    end
    assign l4_rd_data = l4_pv[3] ? l4_pd[3] : POISON;

    task automatic set_addr(input int port, input logic [AW-1:0] a);
        req_addr[port*AW +: AW] = a;
    endtask

    // Cache behaviour: a port drops its request when the broadcast carries its line or it is granted.
    function automatic logic [NP-1:0] drop_mask();
        logic [NP-1:0] m;
        m = '0;
        if (m_bcast_valid === 1'b1) begin
            for (int i = 0; i < NP; i++)
                if (req_valid[i] && req_addr[i*AW +: AW] == m_bcast_addr) m[i] = 1'b1;
            m = m | m_req_ready;
        end
        return m;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NP; i++) set_addr(i, 12'h111 + 12'(i));
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (m_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", m_rd_en); end
        n_vec++; if (m_req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", m_req_ready); end
        n_vec++; if (m_bcast_valid !== 1'b0) begin n_err++; $display("FAIL reset_bcast_valid: got %b want 0", m_bcast_valid); end
        n_vec++; if (m_line_data !== '0) begin n_err++; $display("FAIL reset_line_data: got %h want 0", m_line_data); end
        n_vec++; if (m_bcast_addr !== '0) begin n_err++; $display("FAIL reset_bcast_addr: got %h want 0", m_bcast_addr); end
        n_vec++; if (m_rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr: got %h want 0", m_rd_addr); end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        int t_resp;
        logic [NP-1:0] dm;
        apply_reset();
        set_addr(1, 12'h0A3);
        req_valid = 4'b0010;
        sb.push_back(exp_t'{mask: 4'b0010, addr: 12'h0A3, data: 64'hDEADBEEF_00C0FFEE});
        t_resp = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (c == 0 && (m_rd_en !== 1'b1 || m_rd_addr !== 12'h0A3)) begin
                n_err++; $display("FAIL single_issue: got en=%b addr=%h want en=1 addr=0a3", m_rd_en, m_rd_addr);
            end else if (c != 0 && m_rd_en !== 1'b0) begin
                n_err++; $display("FAIL single_extra_read: cycle %0d got en=%b want 0", c, m_rd_en);
            end
            if (m_bcast_valid === 1'b1) begin
                n_vec++; t_resp = c;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL single_resp: unexpected strobe ready=%b addr=%h want none", m_req_ready, m_bcast_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_req_ready, m_bcast_addr, m_line_data} !== {e.mask, e.addr, e.data}) begin
                        n_err++; $display("FAIL single_resp: got ready=%b addr=%h data=%h want ready=%b addr=%h data=%h",
                                          m_req_ready, m_bcast_addr, m_line_data, e.mask, e.addr, e.data);
                    end
                end
            end else begin
                n_vec++; if (m_req_ready !== '0) begin n_err++; $display("FAIL single_stray_ready: got %b want 0000", m_req_ready); end
            end
            if (c == 4) begin
                n_vec++;
                if (m_line_data !== 64'hDEADBEEF_00C0FFEE) begin
                    n_err++; $display("FAIL single_hold: got %h want deadbeef00c0ffee", m_line_data);
                end
            end
            dm = drop_mask();
            @(posedge clk); #1;
            req_valid = req_valid & ~dm;
        end
        n_vec++; if (t_resp !== 3) begin n_err++; $display("FAIL single_latency: got cycle %0d want 3", t_resp); end
    endtask

    task automatic test_fairness();
        exp_t e;
        int n_resp, t_prev, k_rd;
        apply_reset();
        for (int i = 0; i < NP; i++) set_addr(i, 12'h010 + 12'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++)
            sb.push_back(exp_t'{mask: NP'(1) << (k % 4), addr: 12'h010 + 12'(k % 4), data: ram_fn(12'h010 + 12'(k % 4))});
        k_rd = 0; n_resp = 0; t_prev = -1;
        for (int c = 0; c < 40 && n_resp < 5; c++) begin
            @(negedge clk);
            if (m_rd_en === 1'b1 && k_rd < 5) begin
                n_vec++;
                if (m_rd_addr !== 12'h010 + 12'(k_rd % 4)) begin
                    n_err++; $display("FAIL fair_grant_order: read %0d got addr=%h want %h", k_rd, m_rd_addr, 12'h010 + 12'(k_rd % 4));
                end
                k_rd++;
            end
            if (m_bcast_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL fair_resp: unexpected strobe ready=%b addr=%h want none", m_req_ready, m_bcast_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_req_ready, m_bcast_addr, m_line_data} !== {e.mask, e.addr, e.data}) begin
                        n_err++; $display("FAIL fair_resp: got ready=%b addr=%h data=%h want ready=%b addr=%h data=%h",
                                          m_req_ready, m_bcast_addr, m_line_data, e.mask, e.addr, e.data);
                    end
                end
                n_vec++;
                if (c - t_prev !== 4) begin n_err++; $display("FAIL fair_spacing: got %0d cycles want 4", c - t_prev); end
                t_prev = c;
                n_resp++;
            end else begin
                n_vec++; if (m_req_ready !== '0) begin n_err++; $display("FAIL fair_stray_ready: got %b want 0000", m_req_ready); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL fair_timeout: got %0d pending want 0", sb.size()); end
        req_valid = '0;
    endtask

    task automatic test_dedup();
        exp_t e;
        int n_rd;
        logic [NP-1:0] dm;
        apply_reset();
        set_addr(0, 12'h055);
        set_addr(2, 12'h055);
        req_valid = 4'b0101;
        sb.push_back(exp_t'{mask: 4'b0001, addr: 12'h055, data: ram_fn(12'h055)});
        n_rd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_rd_en === 1'b1) n_rd++;
            if (m_bcast_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL dedup_resp: unexpected strobe ready=%b addr=%h want none", m_req_ready, m_bcast_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_req_ready, m_bcast_addr, m_line_data} !== {e.mask, e.addr, e.data}) begin
                        n_err++; $display("FAIL dedup_resp: got ready=%b addr=%h data=%h want ready=%b addr=%h data=%h",
                                          m_req_ready, m_bcast_addr, m_line_data, e.mask, e.addr, e.data);
                    end
                end
            end else begin
                n_vec++; if (m_req_ready !== '0) begin n_err++; $display("FAIL dedup_stray_ready: got %b want 0000", m_req_ready); end
            end
            dm = drop_mask();
            @(posedge clk); #1;
            req_valid = req_valid & ~dm;
        end
        n_vec++; if (n_rd !== 1) begin n_err++; $display("FAIL dedup_reads: got %0d reads want 1", n_rd); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL dedup_timeout: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_withdrawal();
        exp_t e;
        logic [NP-1:0] dm;
        apply_reset();
        set_addr(0, 12'h0C0);
        set_addr(1, 12'h0B1);
        set_addr(3, 12'h0C3);
        req_valid = 4'b0010;
        sb.push_back(exp_t'{mask: 4'b0010, addr: 12'h0B1, data: ram_fn(12'h0B1)});
        sb.push_back(exp_t'{mask: 4'b1000, addr: 12'h0C3, data: ram_fn(12'h0C3)});
        sb.push_back(exp_t'{mask: 4'b0001, addr: 12'h0C0, data: ram_fn(12'h0C0)});
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (m_bcast_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL withdraw_resp: unexpected strobe ready=%b addr=%h want none", m_req_ready, m_bcast_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_req_ready, m_bcast_addr, m_line_data} !== {e.mask, e.addr, e.data}) begin
                        n_err++; $display("FAIL withdraw_resp: got ready=%b addr=%h data=%h want ready=%b addr=%h data=%h",
                                          m_req_ready, m_bcast_addr, m_line_data, e.mask, e.addr, e.data);
                    end
                end
            end else begin
                n_vec++; if (m_req_ready !== '0) begin n_err++; $display("FAIL withdraw_stray_ready: got %b want 0000", m_req_ready); end
            end
            dm = drop_mask();
            @(posedge clk); #1;
            req_valid = req_valid & ~dm;
            if (c == 0) req_valid = (req_valid & 4'b1101) | 4'b1001;
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL withdraw_timeout: got %0d pending want 0", sb.size()); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        logic [NP-1:0] dm;
        apply_reset();
        set_addr(1, 12'h0E1);
        set_addr(2, 12'h0E2);
        req_valid = 4'b0100;
        sb.push_back(exp_t'{mask: 4'b0100, addr: 12'h0E2, data: ram_fn(12'h0E2)});
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 6) begin
                n_vec++;
                if ({m_req_ready, m_bcast_valid, m_rd_en} !== '0) begin
                    n_err++; $display("FAIL abort_strobes: got ready=%b bv=%b en=%b want all 0", m_req_ready, m_bcast_valid, m_rd_en);
                end
                n_vec++;
                if ({m_line_data, m_bcast_addr, m_rd_addr} !== '0) begin
                    n_err++; $display("FAIL abort_regs: got data=%h baddr=%h raddr=%h want all 0", m_line_data, m_bcast_addr, m_rd_addr);
                end
            end
            if (c >= 7) begin
                n_vec++;
                if ({m_req_ready, m_bcast_valid, m_rd_en} !== '0) begin
                    n_err++; $display("FAIL abort_quiet: cycle %0d got ready=%b bv=%b en=%b want all 0", c, m_req_ready, m_bcast_valid, m_rd_en);
                end
            end
            if (m_bcast_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL abort_resp: unexpected strobe ready=%b addr=%h want none", m_req_ready, m_bcast_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_req_ready, m_bcast_addr, m_line_data} !== {e.mask, e.addr, e.data}) begin
                        n_err++; $display("FAIL abort_resp: got ready=%b addr=%h data=%h want ready=%b addr=%h data=%h",
                                          m_req_ready, m_bcast_addr, m_line_data, e.mask, e.addr, e.data);
                    end
                end
            end
            if (c == 12) begin
                n_vec++; if (m_line_data !== '0) begin n_err++; $display("FAIL abort_late_data: got %h want 0", m_line_data); end
            end
            dm = drop_mask();
            @(posedge clk); #1;
            req_valid = req_valid & ~dm;
            if (c == 3) req_valid[1] = 1'b1;
            if (c == 4) rst = 1'b1;
            if (c == 5) begin rst = 1'b0; req_valid[1] = 1'b0; end
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL abort_first_resp: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_latency_sweep();
        int t_grant, t_ready, ml;
        logic rd, seen;
        logic [NP-1:0] rdy;
        logic [DW-1:0] ld;
        for (int p = 0; p < 2; p++) begin
            ml = (p == 0) ? 1 : 4;
            apply_reset();
            set_addr(3, 12'h1F3);
            req_valid = 4'b1000;
            t_grant = -1; t_ready = -1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                rd  = (p == 0) ? l1_rd_en : l4_rd_en;
                rdy = (p == 0) ? l1_req_ready : l4_req_ready;
                ld  = (p == 0) ? l1_line_data : l4_line_data;
                if (rd === 1'b1 && t_grant < 0) t_grant = c;
                if (rdy !== '0 && t_ready < 0) begin
                    t_ready = c;
                    n_vec++;
                    if (rdy !== 4'b1000 || ld !== ram_fn(12'h1F3)) begin
                        n_err++; $display("FAIL sweep_resp ml=%0d: got ready=%b data=%h want ready=1000 data=%h", ml, rdy, ld, ram_fn(12'h1F3));
                    end
                end else if (t_ready >= 0 && c == t_ready + 1) begin
                    n_vec++;
                    if (ld !== ram_fn(12'h1F3)) begin
                        n_err++; $display("FAIL sweep_hold ml=%0d: got %h want %h", ml, ld, ram_fn(12'h1F3));
                    end
                end
                seen = rdy[3];
                @(posedge clk); #1;
                if (seen) req_valid = '0;
            end
            n_vec++;
            if (t_grant !== 0 || t_ready - t_grant !== ml + 1) begin
                n_err++; $display("FAIL sweep_latency ml=%0d: got grant=%0d ready=%0d want grant=0 ready=%0d", ml, t_grant, t_ready, ml + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_dedup();
        test_withdrawal();
        test_reset_mid_read();
        test_latency_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
